// File: rtl/rob_commit_ctrl_pkg.sv
// Shared ROB geometry, entry layout and commit state encoding.
// Tag = entry index + 1, so tag 0 (NO_TAG) always means "no pending producer".
package rob_commit_ctrl_pkg;

   localparam int DEPTH = 7;
   localparam int TAG_W = 3;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [TAG_W:0]   cnt_t;

   localparam tag_t NO_TAG = '0;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_FLUSH
   } state_t;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic        has_rd;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mispredict;
      logic [31:0] target;
   } entry_t;

   function automatic tag_t ptr_inc(input tag_t p);
      return (p == tag_t'(DEPTH - 1)) ? '0 : p + tag_t'(1);
   endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Decoder, CDB, operand-query and regfile-side signals of the ROB commit controller.
interface rob_commit_ctrl_if;
   import rob_commit_ctrl_pkg::*;

   logic        alloc_valid;
   logic        alloc_ready;
   logic        alloc_has_rd;
   logic [4:0]  alloc_rd;
   tag_t        alloc_tag;

   logic        cdb_valid;
   tag_t        cdb_tag;
   logic [31:0] cdb_data;
   logic        cdb_mispredict;
   logic [31:0] cdb_target;

   tag_t        qry1_tag;
   logic        qry1_ready;
   logic [31:0] qry1_data;
   tag_t        qry2_tag;
   logic        qry2_ready;
   logic [31:0] qry2_data;

   logic        rf_we;
   logic [4:0]  rf_reg_id;
   logic [31:0] rf_data;
   tag_t        rf_rob_id;

   logic        flush_out;
   logic [31:0] redirect_pc;
   cnt_t        occupancy;

   modport slave (
      input  alloc_valid, alloc_has_rd, alloc_rd,
      input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
      input  qry1_tag, qry2_tag,
      output alloc_ready, alloc_tag,
      output qry1_ready, qry1_data, qry2_ready, qry2_data,
      output rf_we, rf_reg_id, rf_data, rf_rob_id,
      output flush_out, redirect_pc, occupancy
   );

   modport master (
      output alloc_valid, alloc_has_rd, alloc_rd,
      output cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
      output qry1_tag, qry2_tag,
      input  alloc_ready, alloc_tag,
      input  qry1_ready, qry1_data, qry2_ready, qry2_data,
      input  rf_we, rf_reg_id, rf_data, rf_rob_id,
      input  flush_out, redirect_pc, occupancy
   );

endinterface

// File: rtl/rob_entry_array.sv
// ROB entry storage: allocate, CDB-capture, retire and flush-clear write ports;
// a head read port for the commit logic and two operand-query read ports.
module rob_entry_array
   import rob_commit_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        alloc_we_i,
   input  tag_t        alloc_idx_i,
   input  logic        alloc_has_rd_i,
   input  logic [4:0]  alloc_rd_i,
   input  logic        cdb_we_i,
   input  tag_t        cdb_idx_i,
   input  logic [31:0] cdb_data_i,
   input  logic        cdb_mispredict_i,
   input  logic [31:0] cdb_target_i,
   input  logic        retire_i,
   input  tag_t        retire_idx_i,
   input  logic        clear_all_i,
   input  tag_t        head_idx_i,
   output entry_t      head_o,
   input  tag_t        qry1_idx_i,
   output logic        qry1_ready_o,
   output logic [31:0] qry1_data_o,
   input  tag_t        qry2_idx_i,
   output logic        qry2_ready_o,
   output logic [31:0] qry2_data_o
);

   entry_t mem_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (alloc_we_i) begin
            mem_q[alloc_idx_i].valid      <= 1'b1;
            mem_q[alloc_idx_i].ready      <= 1'b0;
            mem_q[alloc_idx_i].has_rd     <= alloc_has_rd_i;
            mem_q[alloc_idx_i].rd         <= alloc_rd_i;
            mem_q[alloc_idx_i].mispredict <= 1'b0;
         end
         // Results for tags that are out of range or not live are dropped.
         if (cdb_we_i && (cdb_idx_i < tag_t'(DEPTH)) && mem_q[cdb_idx_i].valid) begin
            mem_q[cdb_idx_i].ready      <= 1'b1;
            mem_q[cdb_idx_i].data       <= cdb_data_i;
            mem_q[cdb_idx_i].mispredict <= cdb_mispredict_i;
            mem_q[cdb_idx_i].target     <= cdb_target_i;
         end
         if (retire_i) begin
            mem_q[retire_idx_i].valid <= 1'b0;
            mem_q[retire_idx_i].ready <= 1'b0;
         end
         if (clear_all_i) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[i].valid <= 1'b0;
               mem_q[i].ready <= 1'b0;
            end
         end
      end
   end

   assign head_o = mem_q[head_idx_i];

   assign qry1_ready_o = (qry1_idx_i < tag_t'(DEPTH)) && mem_q[qry1_idx_i].valid
                         && mem_q[qry1_idx_i].ready;
   assign qry1_data_o  = qry1_ready_o ? mem_q[qry1_idx_i].data : '0;
   assign qry2_ready_o = (qry2_idx_i < tag_t'(DEPTH)) && mem_q[qry2_idx_i].valid
                         && mem_q[qry2_idx_i].ready;
   assign qry2_data_o  = qry2_ready_o ? mem_q[qry2_idx_i].data : '0;

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB commit controller: tag allocation, CDB capture, one retire per cycle into the
// regfile write port, and a RUN -> DRAIN -> FLUSH sequence when a mispredicted branch retires.
module rob_commit_ctrl
   import rob_commit_ctrl_pkg::*;
(
   input  logic             clk_in,
   input  logic             rstn_in,
   rob_commit_ctrl_if.slave rob
);

   state_t      state_q, state_d;
   tag_t        head_q, head_d;
   tag_t        tail_q, tail_d;
   cnt_t        count_q, count_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_reg_q, rf_reg_d;
   logic [31:0] rf_data_q, rf_data_d;
   tag_t        rf_rob_q, rf_rob_d;
   logic [31:0] target_q, target_d;

   entry_t      head_ent;
   logic        alloc_ok;
   logic        alloc_fire;
   logic        commit_fire;
   logic        cdb_we;
   logic        clear_all;
   logic        q1_rdy, q2_rdy;
   logic [31:0] q1_dat, q2_dat;

   if (DEPTH > (2 ** TAG_W) - 1) begin : g_depth_chk
      $error("rob_commit_ctrl: DEPTH does not fit the non-zero tag space");
   end

   // Full means full: a same-cycle retire never frees a slot for allocation.
   assign alloc_ok   = (count_q < cnt_t'(DEPTH)) && (state_q == ST_RUN);
   assign alloc_fire = rob.alloc_valid && alloc_ok;

   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      rf_we_d     = 1'b0;
      rf_reg_d    = rf_reg_q;
      rf_data_d   = rf_data_q;
      rf_rob_d    = rf_rob_q;
      target_d    = target_q;
      commit_fire = 1'b0;
      cdb_we      = 1'b0;
      clear_all   = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            cdb_we      = rob.cdb_valid && (rob.cdb_tag != NO_TAG);
            commit_fire = head_ent.valid && head_ent.ready;
            if (alloc_fire) begin
               tail_d = ptr_inc(tail_q);
            end
            if (commit_fire) begin
               head_d    = ptr_inc(head_q);
               rf_we_d   = head_ent.has_rd && (head_ent.rd != 5'd0);
               rf_reg_d  = head_ent.rd;
               rf_data_d = head_ent.data;
               rf_rob_d  = head_q + tag_t'(1);
               if (head_ent.mispredict) begin
                  target_d = head_ent.target;
                  state_d  = ST_DRAIN;
               end
            end
            case ({alloc_fire, commit_fire})
               2'b10:   count_d = count_q + cnt_t'(1);
               2'b01:   count_d = count_q - cnt_t'(1);
               default: count_d = count_q;
            endcase
         end
         ST_DRAIN: begin
            // Squash on the way into FLUSH so the flush cycle already shows an empty ROB.
            clear_all = 1'b1;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            state_d   = ST_FLUSH;
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q   <= ST_RUN;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         rf_we_q   <= 1'b0;
         rf_reg_q  <= '0;
         rf_data_q <= '0;
         rf_rob_q  <= '0;
         target_q  <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         rf_we_q   <= rf_we_d;
         rf_reg_q  <= rf_reg_d;
         rf_data_q <= rf_data_d;
         rf_rob_q  <= rf_rob_d;
         target_q  <= target_d;
      end
   end

   rob_entry_array u_entries (
      .clk_i            (clk_in),
      .rst_ni           (rstn_in),
      .alloc_we_i       (alloc_fire),
      .alloc_idx_i      (tail_q),
      .alloc_has_rd_i   (rob.alloc_has_rd),
      .alloc_rd_i       (rob.alloc_rd),
      .cdb_we_i         (cdb_we),
      .cdb_idx_i        (rob.cdb_tag - tag_t'(1)),
      .cdb_data_i       (rob.cdb_data),
      .cdb_mispredict_i (rob.cdb_mispredict),
      .cdb_target_i     (rob.cdb_target),
      .retire_i         (commit_fire),
      .retire_idx_i     (head_q),
      .clear_all_i      (clear_all),
      .head_idx_i       (head_q),
      .head_o           (head_ent),
      .qry1_idx_i       (rob.qry1_tag - tag_t'(1)),
      .qry1_ready_o     (q1_rdy),
      .qry1_data_o      (q1_dat),
      .qry2_idx_i       (rob.qry2_tag - tag_t'(1)),
      .qry2_ready_o     (q2_rdy),
      .qry2_data_o      (q2_dat)
   );

   assign rob.alloc_ready = alloc_ok;
   assign rob.alloc_tag   = tail_q + tag_t'(1);

   assign rob.qry1_ready  = (rob.qry1_tag != NO_TAG) && q1_rdy;
   assign rob.qry1_data   = rob.qry1_ready ? q1_dat : '0;
   assign rob.qry2_ready  = (rob.qry2_tag != NO_TAG) && q2_rdy;
   assign rob.qry2_data   = rob.qry2_ready ? q2_dat : '0;

   assign rob.rf_we       = rf_we_q;
   assign rob.rf_reg_id   = rf_reg_q;
   assign rob.rf_data     = rf_data_q;
   assign rob.rf_rob_id   = rf_rob_q;

   assign rob.flush_out   = (state_q == ST_FLUSH);
   assign rob.redirect_pc = (state_q == ST_FLUSH) ? target_q : '0;
   assign rob.occupancy   = count_q;

endmodule
